// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction sequencer:
// FSM state encoding, coin denominations and the item price lookup.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ITEM   = 2'd2,
    CHANGE = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_20 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  function automatic logic [5:0] coin_value(input logic [1:0] code);
    logic [5:0] v;
    case (code)
      COIN_5:  v = 6'd5;
      COIN_10: v = 6'd10;
      COIN_20: v = 6'd20;
      default: v = 6'd50;
    endcase
    return v;
  endfunction

  // Prices come from the top-level parameters, so they are passed in.
  function automatic logic [31:0] price_of(input logic [1:0]  sel,
                                           input logic [31:0] p0,
                                           input logic [31:0] p1,
                                           input logic [31:0] p2,
                                           input logic [31:0] p3);
    logic [31:0] p;
    case (sel)
      2'd0:    p = p0;
      2'd1:    p = p1;
      2'd2:    p = p2;
      default: p = p3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change-coin selector: largest non-empty denomination (20/10/5)
// that does not exceed the remaining balance.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int BAL_W = 8
) (
  input  logic [BAL_W-1:0] balance_i,
  input  logic [2:0]       hop_empty_i,
  output logic             eligible_o,
  output logic [1:0]       chg_code_o
);

  always_comb begin
    eligible_o = 1'b0;
    chg_code_o = COIN_5;
    if (balance_i >= BAL_W'(coin_value(COIN_20)) && !hop_empty_i[2]) begin
      eligible_o = 1'b1;
      chg_code_o = COIN_20;
    end else if (balance_i >= BAL_W'(coin_value(COIN_10)) && !hop_empty_i[1]) begin
      eligible_o = 1'b1;
      chg_code_o = COIN_10;
    end else if (balance_i >= BAL_W'(coin_value(COIN_5)) && !hop_empty_i[0]) begin
      eligible_o = 1'b1;
      chg_code_o = COIN_5;
    end
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, price check, item handoff and
// greedy change payout. Both handoffs use valid/ready: a transfer happens on
// a clock edge where valid && ready; valid and payload hold until then.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int          BAL_W  = 8,
  parameter int unsigned PRICE0 = 15,
  parameter int unsigned PRICE1 = 25,
  parameter int unsigned PRICE2 = 40,
  parameter int unsigned PRICE3 = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid_i,
  input  logic [1:0]       coin_code_i,
  input  logic             vend_req_i,
  input  logic [1:0]       item_sel_i,
  input  logic             cancel_i,
  input  logic [2:0]       hop_empty_i,
  output logic             item_valid_o,
  output logic [1:0]       item_id_o,
  input  logic             item_ready_i,
  output logic             chg_valid_o,
  output logic [1:0]       chg_code_o,
  input  logic             chg_ready_i,
  output logic [BAL_W-1:0] balance_o,
  output logic             busy_o,
  output logic             vend_ok_o,
  output logic             vend_fail_o,
  output logic             coin_reject_o,
  output logic             chg_short_o,
  output vend_state_e      dbg_state_o
);

  vend_state_e      state_q;
  logic [BAL_W-1:0] bal_q;
  logic [1:0]       sel_q, item_id_q, chg_code_q;
  logic             item_valid_q, chg_valid_q, busy_q;
  logic             vend_ok_q, vend_fail_q, coin_reject_q, chg_short_q;

  logic [BAL_W:0]   coin_sum;
  logic [BAL_W-1:0] bal_credit, price, chg_val;
  logic             sel_elig;
  logic [1:0]       sel_code;

  // Extra carry bit detects overflow; an overflowing coin is refused.
  assign coin_sum   = {1'b0, bal_q} + (BAL_W+1)'(coin_value(coin_code_i));
  assign bal_credit = (coin_valid_i && !coin_sum[BAL_W]) ? coin_sum[BAL_W-1:0] : bal_q;
  assign price      = BAL_W'(price_of(sel_q, PRICE0, PRICE1, PRICE2, PRICE3));
  assign chg_val    = BAL_W'(coin_value(chg_code_q));

  vend_change_sel #(.BAL_W(BAL_W)) u_change_sel (
    .balance_i   (bal_q),
    .hop_empty_i (hop_empty_i),
    .eligible_o  (sel_elig),
    .chg_code_o  (sel_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bal_q         <= '0;
      sel_q         <= 2'd0;
      item_id_q     <= 2'd0;
      chg_code_q    <= COIN_5;
      item_valid_q  <= 1'b0;
      chg_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      vend_ok_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      chg_short_q   <= 1'b0;
    end else begin
      vend_ok_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      chg_short_q   <= 1'b0;
      if (coin_valid_i && state_q != IDLE) coin_reject_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (coin_valid_i && coin_sum[BAL_W]) coin_reject_q <= 1'b1;
          bal_q <= bal_credit;
          if (cancel_i) begin
            if (bal_credit != '0) begin
              state_q <= CHANGE;
              busy_q  <= 1'b1;
            end
          end else if (vend_req_i) begin
            sel_q   <= item_sel_i;
            state_q <= CHECK;
            busy_q  <= 1'b1;
          end
        end
        CHECK: begin
          if (bal_q >= price) begin
            bal_q        <= bal_q - price;
            item_valid_q <= 1'b1;
            item_id_q    <= sel_q;
            state_q      <= ITEM;
          end else begin
            vend_fail_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ITEM: begin
          if (item_ready_i) begin
            vend_ok_q    <= 1'b1;
            item_valid_q <= 1'b0;
            item_id_q    <= 2'd0;
            if (bal_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              // First coin is offered right away; later coins see a bubble.
              chg_valid_q <= sel_elig;
              chg_code_q  <= sel_code;
              state_q     <= CHANGE;
            end
          end
        end
        CHANGE: begin
          if (chg_valid_q) begin
            if (chg_ready_i) begin
              bal_q       <= bal_q - chg_val;
              chg_valid_q <= 1'b0;
              chg_code_q  <= COIN_5;
              if (bal_q == chg_val) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end else if (bal_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sel_elig) begin
            chg_valid_q <= 1'b1;
            chg_code_q  <= sel_code;
          end else begin
            chg_short_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign item_valid_o  = item_valid_q;
  assign item_id_o     = item_id_q;
  assign chg_valid_o   = chg_valid_q;
  assign chg_code_o    = chg_code_q;
  assign balance_o     = bal_q;
  assign busy_o        = busy_q;
  assign vend_ok_o     = vend_ok_q;
  assign vend_fail_o   = vend_fail_q;
  assign coin_reject_o = coin_reject_q;
  assign chg_short_o   = chg_short_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: one-cycle vector table plus a
// hand-written asynchronous reset sequence in the middle of a change payout.
module tb_vend_txn_controller;
  import vend_pkg::*;

  logic        clk, rst_n;
  logic        coin_valid, vend_req, cancel, item_ready, chg_ready;
  logic [1:0]  coin_code, item_sel;
  logic [2:0]  hop_empty;
  logic        item_valid, chg_valid, busy, vend_ok, vend_fail, coin_reject, chg_short;
  logic [1:0]  item_id, chg_code;
  logic [7:0]  balance;
  vend_state_e dbg_state;

  vend_txn_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_valid_i  (coin_valid),
    .coin_code_i   (coin_code),
    .vend_req_i    (vend_req),
    .item_sel_i    (item_sel),
    .cancel_i      (cancel),
    .hop_empty_i   (hop_empty),
    .item_valid_o  (item_valid),
    .item_id_o     (item_id),
    .item_ready_i  (item_ready),
    .chg_valid_o   (chg_valid),
    .chg_code_o    (chg_code),
    .chg_ready_i   (chg_ready),
    .balance_o     (balance),
    .busy_o        (busy),
    .vend_ok_o     (vend_ok),
    .vend_fail_o   (vend_fail),
    .coin_reject_o (coin_reject),
    .chg_short_o   (chg_short),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {balance, item_valid, item_id, chg_valid, chg_code, busy, ok, fail, reject, short}
  logic [18:0] act_vec;
  assign act_vec = {balance, item_valid, item_id, chg_valid, chg_code,
                    busy, vend_ok, vend_fail, coin_reject, chg_short};

  typedef struct {
    logic        cv;
    logic [1:0]  cc;
    logic        vr;
    logic [1:0]  isel;
    logic        cn;
    logic [2:0]  he;
    logic        ir;
    logic        cr;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add_row(input int cv, input int cc, input int vr, input int isel,
                         input int cn, input int he, input int ir, input int cr,
                         input int bal, input int iv, input int iid, input int chv,
                         input int chc, input int bsy, input int ok, input int fl,
                         input int rej, input int sh);
    vec_t v;
    v.cv = 1'(cv); v.cc = 2'(cc); v.vr = 1'(vr); v.isel = 2'(isel);
    v.cn = 1'(cn); v.he = 3'(he); v.ir = 1'(ir); v.cr = 1'(cr);
    v.exp = {8'(bal), 1'(iv), 2'(iid), 1'(chv), 2'(chc),
             1'(bsy), 1'(ok), 1'(fl), 1'(rej), 1'(sh)};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    coin_valid = v.cv; coin_code = v.cc; vend_req = v.vr; item_sel = v.isel;
    cancel = v.cn; hop_empty = v.he; item_ready = v.ir; chg_ready = v.cr;
  endtask

  task automatic check(input string name, input logic [18:0] exp);
    checks++;
    if (act_vec !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (bal act=%0d exp=%0d)",
               name, act_vec, exp, act_vec[18:11], exp[18:11]);
    end
  endtask

  initial begin
    vec_t idle_v;
    idle_v = '{cv: 1'b0, cc: 2'd0, vr: 1'b0, isel: 2'd0, cn: 1'b0,
               he: 3'd0, ir: 1'b0, cr: 1'b0, exp: 19'd0};
    drive(idle_v);
    rst_n = 1'b0;

    // purchase item 1 from 40, change 10 then 5; hop_empty flips while a coin is held
    add_row(1,2,0,0,0,0,0,0,  20,0,0,0,0,0,0,0,0,0);
    add_row(1,2,0,0,0,0,0,0,  40,0,0,0,0,0,0,0,0,0);
    add_row(0,0,1,1,0,0,0,0,  40,0,0,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,0,0,  15,1,1,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,0,0,  15,1,1,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,1,0,  15,0,0,1,1,1,1,0,0,0);
    add_row(0,0,0,0,0,7,0,0,  15,0,0,1,1,1,0,0,0,0);
    add_row(0,0,0,0,0,7,0,1,   5,0,0,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,0,1,   5,0,0,1,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,0,1,   0,0,0,0,0,0,0,0,0,0);
    add_row(0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0,0,0);
    // insufficient balance
    add_row(1,1,0,0,0,0,0,0,  10,0,0,0,0,0,0,0,0,0);
    add_row(0,0,1,0,0,0,0,0,  10,0,0,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,0,0,  10,0,0,0,0,0,0,1,0,0);
    add_row(0,0,0,0,0,0,0,0,  10,0,0,0,0,0,0,0,0,0);
    // cancel 50 with the 20 hopper empty: five 10s
    add_row(1,2,0,0,0,0,0,0,  30,0,0,0,0,0,0,0,0,0);
    add_row(1,2,0,0,0,0,0,0,  50,0,0,0,0,0,0,0,0,0);
    add_row(0,0,0,0,1,4,0,0,  50,0,0,0,0,1,0,0,0,0);
    for (int k = 1; k <= 5; k++) begin
      add_row(0,0,0,0,0,4,0,1, 50-10*(k-1),0,0,1,1,1,0,0,0,0);
      add_row(0,0,0,0,0,4,0,1, 50-10*k,    0,0,0,0,(k<5)?1:0,0,0,0,0);
    end
    // cancel with zero balance stays idle
    add_row(0,0,0,0,1,0,0,0,   0,0,0,0,0,0,0,0,0,0);
    add_row(0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0,0,0);
    // change shortage: 15 with 10 and 5 hoppers empty
    add_row(1,1,0,0,0,0,0,0,  10,0,0,0,0,0,0,0,0,0);
    add_row(1,0,0,0,0,0,0,0,  15,0,0,0,0,0,0,0,0,0);
    add_row(0,0,0,0,1,3,0,0,  15,0,0,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,3,0,0,  15,0,0,0,0,0,0,0,0,1);
    add_row(0,0,0,0,0,0,0,0,  15,0,0,0,0,0,0,0,0,0);
    // fill to 240, then overflow rejection
    for (int k = 1; k <= 4; k++)
      add_row(1,3,0,0,0,0,0,0, 15+50*k,0,0,0,0,0,0,0,0,0);
    add_row(1,2,0,0,0,0,0,0, 235,0,0,0,0,0,0,0,0,0);
    add_row(1,0,0,0,0,0,0,0, 240,0,0,0,0,0,0,0,0,0);
    add_row(1,3,0,0,0,0,0,0, 240,0,0,0,0,0,0,0,1,0);
    add_row(0,0,0,0,0,0,0,0, 240,0,0,0,0,0,0,0,0,0);
    // item 3; coin, vend_req and cancel during ITEM are refused/ignored
    add_row(0,0,1,3,0,0,0,0, 240,0,0,0,0,1,0,0,0,0);
    add_row(0,0,0,0,0,0,0,0, 175,1,3,0,0,1,0,0,0,0);
    add_row(1,3,1,0,1,0,0,0, 175,1,3,0,0,1,0,0,1,0);
    add_row(0,0,0,0,0,0,1,0, 175,0,0,1,2,1,1,0,0,0);
    add_row(0,0,0,0,0,0,0,0, 175,0,0,1,2,1,0,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 19'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), vecs[i].exp);
    end

    // asynchronous reset while a change coin is pending with chg_ready low
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_change", 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle_v);
    coin_valid = 1'b1;
    coin_code  = COIN_5;
    @(posedge clk);
    #1;
    check("coin_after_reset", {8'd5, 11'd0});
    @(negedge clk);
    drive(idle_v);
    @(posedge clk);
    #1;
    check("idle_after_reset", {8'd5, 11'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending machine datapath.
- Accumulates a coin balance, checks it against a per-item price table, hands off one item to the dispenser through a valid/ready handshake, then returns change one coin per handshake using greedy denomination selection.
- Sits between the coin acceptor, the keypad, the item dispenser and the coin hopper.

Parameters:
- BAL_W, 8, balance width in money units; balance saturates at 2^BAL_W-1 only through coin rejection, never wraps.
- PRICE0, 15, price of item 0 in units.
- PRICE1, 25, price of item 1.
- PRICE2, 40, price of item 2.
- PRICE3, 65, price of item 3.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle pulse: coin inserted
- coin_code  in  2  00=5, 01=10, 10=20, 11=50 units
- vend_req  in  1  one-cycle pulse: purchase request
- item_sel  in  2  item index, sampled with vend_req
- cancel  in  1  one-cycle pulse: refund whole balance
- hop_empty  in  3  per-denomination hopper empty flags [0]=5, [1]=10, [2]=20
- item_valid  out  1  item dispense request
- item_id  out  2  item to dispense, stable while item_valid
- item_ready  in  1  dispenser accepts item
- chg_valid  out  1  change coin request
- chg_code  out  2  00=5, 01=10, 10=20; stable while chg_valid
- chg_ready  in  1  hopper accepts coin
- balance  out  BAL_W  current credit
- busy  out  1  high in any state except IDLE
- vend_ok  out  1  one-cycle pulse: item dispensed
- vend_fail  out  1  one-cycle pulse: insufficient balance
- coin_reject  out  1  one-cycle pulse: coin not credited
- chg_short  out  1  one-cycle pulse: change could not be fully paid

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: balance=0, item_valid=0, chg_valid=0, busy=0, and all pulse outputs 0. Reset mid-handshake drops item_valid/chg_valid immediately; the pending item or coin is abandoned.
- All outputs are registered.
- States:
  - IDLE:
    - coin_valid: balance += value next cycle. If the sum exceeds 2^BAL_W-1, the balance is unchanged and coin_reject pulses.
    - vend_req (checked after coin in the same cycle): latch item_sel, go to CHECK.
    - cancel: go to CHANGE. If balance=0, go straight back to IDLE instead.
    - Priority when simultaneous: cancel > vend_req. The coin is still credited in the same cycle.
  - CHECK (1 cycle):
    - balance >= price: balance -= price, go to ITEM.
    - Otherwise: pulse vend_fail, go to IDLE with the balance kept.
  - ITEM:
    - item_valid=1, item_id=latched selection.
    - On item_valid&&item_ready: pulse vend_ok, go to CHANGE. If the remaining balance is 0, go to IDLE instead.
  - CHANGE:
    - Each coin, choose the largest non-empty denomination whose value <= balance (20, then 10, then 5). Assert chg_valid with chg_code.
    - On chg_valid&&chg_ready: balance -= value. Re-select next cycle, so there is one bubble cycle between coins.
    - Balance reaches 0: go to IDLE.
    - No eligible denomination while balance>0: pulse chg_short, go to IDLE with the residual balance retained as credit.
    - hop_empty is sampled only when selecting. Once chg_valid is asserted, chg_code is held until the handshake completes.
- Any coin_valid outside IDLE: coin_reject pulses and the coin is not credited.
- vend_req and cancel outside IDLE are ignored.
- Latency:
  - vend_req to item_valid = 2 cycles.
  - item handshake to first chg_valid = 1 cycle.
- Arithmetic:
  - Coin adds use BAL_W+1 bits for the overflow check.
  - Prices are compared zero-extended to BAL_W.
  - Balance never goes negative.

Decomposition:
- Package vend_pkg holds:
  - state enum: IDLE, CHECK, ITEM, CHANGE;
  - coin code constants and the coin-value function (code to units);
  - the price lookup function driven by the PRICE parameters.
- One sub-module, vend_change_sel: combinational greedy selector. Inputs balance and hop_empty; outputs eligible flag and chg_code. It is instanced inside the controller.

Test Plan:
1. Coins 20+20 (balance 40), vend_req item_sel=1 (price 25) -> item_valid, item_id=1 after 2 cycles; vend_ok; chg_code=01 (10) then 00 (5); balance 0; busy falls.
2. Balance 10, vend_req item 0 (price 15) -> vend_fail pulse, balance stays 10, no item_valid.
3. Balance 50, cancel, hop_empty=3'b100 -> change is 10,10,10,10,10 (five handshakes), balance 0.
4. Balance 15, cancel, hop_empty=3'b011 -> no coin issued, chg_short pulses, balance stays 15.
5. BAL_W=8, balance 240, coin 50 -> coin_reject, balance 240. Coin inserted during ITEM -> coin_reject, balance unchanged.
6. Assert rst_n=0 while chg_valid=1 with chg_ready held low -> chg_valid=0, balance=0, busy=0 immediately. After release, the block accepts a coin normally.
